// File: rtl/rf_alu_exec.sv
// Execute unit: register file, ALU, shifter and iterative multiplier behind a
// valid/ready issue handshake, with registered result and PSR flags.
module rf_alu_exec #(
   parameter int WIDTH   = 16,
   parameter int REGBITS = 4,
   parameter int SHBITS  = $clog2(WIDTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               issue_valid,
   output logic               issue_ready,
   input  logic [3:0]         op,
   input  logic [REGBITS-1:0] rdest,
   input  logic [REGBITS-1:0] rsrc,
   input  logic               use_imm,
   input  logic [WIDTH-1:0]   imm,
   input  logic               write_en,
   output logic [WIDTH-1:0]   result,
   output logic               result_valid,
   output logic [7:0]         psr,
   input  logic [REGBITS-1:0] dbg_addr,
   output logic [WIDTH-1:0]   dbg_data
);

   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_XOR = 4'd2;
   localparam logic [3:0] OP_ADD = 4'd3;
   localparam logic [3:0] OP_SUB = 4'd4;
   localparam logic [3:0] OP_CMP = 4'd5;
   localparam logic [3:0] OP_MOV = 4'd6;
   localparam logic [3:0] OP_LSH = 4'd7;
   localparam logic [3:0] OP_ASH = 4'd8;
   localparam logic [3:0] OP_MUL = 4'd9;
   localparam logic [3:0] OP_LUI = 4'd10;

   localparam int CNTW = $clog2(WIDTH) + 1;
   localparam logic [SHBITS-1:0] WIDTH_S = SHBITS'(WIDTH);

   typedef enum logic {IDLE, BUSY} stateE;
   stateE state, stateNext;

   logic [WIDTH-1:0] regFile [2**REGBITS];
   logic [WIDTH-1:0] opA, opB;
   logic signed [WIDTH-1:0] opASigned;
   logic             accept;

   logic [WIDTH-1:0]  aluResult;
   logic              writesRf;
   logic [WIDTH:0]    addFull;
   logic [WIDTH-1:0]  subDiff;
   logic              addOvf, subOvf;

   logic [SHBITS-1:0] shAmt, shMag;
   logic              shRight, shOver;
   logic [WIDTH-1:0]  shlVal, lshrVal, ashrVal, ashrRaw;

   logic [WIDTH-1:0]   mulA, mulB, mulAcc, mulFinal;
   logic [CNTW-1:0]    mulCount;
   logic [REGBITS-1:0] mulDest;
   logic               mulWe, mulDone;

   logic flagC, flagL, flagF, flagZ, flagN;

   assign issue_ready = (state == IDLE);
   assign accept      = issue_valid && issue_ready;
   assign opA         = regFile[rdest];
   assign opB         = use_imm ? imm : regFile[rsrc];
   assign opASigned   = opA;
   assign dbg_data    = regFile[dbg_addr];
   assign psr         = {flagN, flagZ, flagF, 2'b00, flagL, 1'b0, flagC};

   assign mulFinal = mulAcc + (mulB[0] ? mulA : '0);
   assign mulDone  = (mulCount == CNTW'(1));

   always_comb begin
      shAmt   = opB[SHBITS-1:0];
      shRight = shAmt[SHBITS-1];
      shMag   = shRight ? (~shAmt) + SHBITS'(1) : shAmt;
      shOver  = (shMag >= WIDTH_S);
      // Kept apart from the ternary so the shift stays in signed context
      ashrRaw = opASigned >>> shMag;
      shlVal  = shOver ? '0 : (opA << shMag);
      lshrVal = shOver ? '0 : (opA >> shMag);
      ashrVal = shOver ? {WIDTH{opA[WIDTH-1]}} : ashrRaw;
   end

   always_comb begin
      addFull = {1'b0, opA} + {1'b0, opB};
      subDiff = opA - opB;
      addOvf  = (opA[WIDTH-1] == opB[WIDTH-1]) && (addFull[WIDTH-1] != opA[WIDTH-1]);
      subOvf  = (opA[WIDTH-1] != opB[WIDTH-1]) && (subDiff[WIDTH-1] != opA[WIDTH-1]);
   end

   always_comb begin
      aluResult = '0;
      writesRf  = 1'b1;
      case (op)
         OP_AND: aluResult = opA & opB;
         OP_OR:  aluResult = opA | opB;
         OP_XOR: aluResult = opA ^ opB;
         OP_ADD: aluResult = addFull[WIDTH-1:0];
         OP_SUB: aluResult = subDiff;
         OP_MOV: aluResult = opB;
         OP_LSH: aluResult = shRight ? lshrVal : shlVal;
         OP_ASH: aluResult = shRight ? ashrVal : shlVal;
         OP_LUI: aluResult = opB << (WIDTH / 2);
         OP_MUL: aluResult = '0;
         default: writesRf = 1'b0;
      endcase
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (accept && op == OP_MUL) stateNext = BUSY;
         BUSY: if (mulDone) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         for (int unsigned i = 0; i < 2**REGBITS; i++) regFile[i] <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         {flagC, flagL, flagF, flagZ, flagN} <= '0;
         mulA     <= '0;
         mulB     <= '0;
         mulAcc   <= '0;
         mulCount <= '0;
         mulDest  <= '0;
         mulWe    <= 1'b0;
      end else begin
         state        <= stateNext;
         result_valid <= 1'b0;
         if (state == IDLE && accept) begin
            if (op == OP_MUL) begin
               mulA     <= opA;
               mulB     <= opB;
               mulAcc   <= '0;
               mulCount <= CNTW'(WIDTH);
               mulDest  <= rdest;
               mulWe    <= write_en;
            end else begin
               result       <= aluResult;
               result_valid <= 1'b1;
               if (write_en && writesRf) regFile[rdest] <= aluResult;
               case (op)
                  OP_ADD: begin
                     flagC <= addFull[WIDTH];
                     flagF <= addOvf;
                  end
                  OP_SUB: begin
                     flagC <= (opA < opB);
                     flagF <= subOvf;
                  end
                  OP_CMP: begin
                     flagZ <= (opA == opB);
                     flagN <= ($signed(opA) < $signed(opB));
                     flagL <= (opA < opB);
                  end
                  default: ;
               endcase
            end
         end else if (state == BUSY) begin
            // Shift-add: the last step's sum goes straight to result/RF
            mulAcc   <= mulFinal;
            mulA     <= mulA << 1;
            mulB     <= mulB >> 1;
            mulCount <= mulCount - CNTW'(1);
            if (mulDone) begin
               result       <= mulFinal;
               result_valid <= 1'b1;
               if (mulWe) regFile[mulDest] <= mulFinal;
            end
         end
      end
   end

endmodule

// File: tb/tb_rf_alu_exec.sv
// Directed self-checking bench for rf_alu_exec (WIDTH=16, REGBITS=4) using
// immediate assertions with hand-computed expected values.
module tb_rf_alu_exec;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid;
   logic        issue_ready;
   logic [3:0]  op;
   logic [3:0]  rdest, rsrc;
   logic        use_imm;
   logic [15:0] imm;
   logic        write_en;
   logic [15:0] result;
   logic        result_valid;
   logic [7:0]  psr;
   logic [3:0]  dbg_addr;
   logic [15:0] dbg_data;

   int errors = 0;
   int checks = 0;

   rf_alu_exec #(.WIDTH(16), .REGBITS(4)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .op(op), .rdest(rdest), .rsrc(rsrc), .use_imm(use_imm), .imm(imm),
      .write_en(write_en), .result(result), .result_valid(result_valid),
      .psr(psr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Presents one instruction for a single accepting edge, returns 1 time unit after it
   task automatic issue(input logic [3:0] o, input logic [3:0] rd, input logic [3:0] rs,
                        input logic ui, input logic [15:0] im, input logic we);
      op = o; rdest = rd; rsrc = rs; use_imm = ui; imm = im; write_en = we;
      issue_valid = 1'b1;
      @(posedge clk); #1;
      issue_valid = 1'b0;
   endtask

   task automatic peek(input logic [3:0] a, output logic [15:0] v);
      dbg_addr = a; #0; #1;
      v = dbg_data;
   endtask

   logic [15:0] rv;
   int busy, pulses;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; issue_valid = 1'b0; op = '0; rdest = '0; rsrc = '0;
      use_imm = 1'b0; imm = '0; write_en = 1'b0; dbg_addr = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      check("rst_ready", issue_ready, 1);
      check("rst_result", result, 0);
      check("rst_valid", result_valid, 0);
      check("rst_psr", psr, 8'h00);
      peek(4'd0, rv); check("rst_r0", rv, 0);

      // Logic ops
      issue(4'd6, 4'd0, 4'd0, 1, 16'hAAAA, 1);
      check("mov_r0", result, 16'hAAAA);
      issue(4'd6, 4'd1, 4'd0, 1, 16'hFFFF, 1);
      issue(4'd0, 4'd0, 4'd1, 0, 16'h0000, 1);
      check("and_result", result, 16'hAAAA);
      check("and_valid", result_valid, 1);
      check("and_psr", psr, 8'h00);
      peek(4'd0, rv); check("and_r0", rv, 16'hAAAA);
      @(posedge clk); #1;
      check("pulse_end", result_valid, 0);
      check("result_hold", result, 16'hAAAA);
      issue(4'd2, 4'd1, 4'd0, 1, 16'h0F0F, 0);
      check("xor_result", result, 16'hF0F0);
      issue(4'd1, 4'd0, 4'd0, 1, 16'h0055, 0);
      check("or_result", result, 16'hAAFF);
      issue(4'd6, 4'd2, 4'd0, 1, 16'h1234, 0);
      check("nowe_result", result, 16'h1234);
      peek(4'd2, rv); check("nowe_r2", rv, 0);

      // Arithmetic and flags
      issue(4'd6, 4'd4, 4'd0, 1, 16'hFFFF, 1);
      issue(4'd3, 4'd4, 4'd0, 1, 16'h0001, 1);
      check("add_carry_res", result, 16'h0000);
      check("add_carry_psr", psr, 8'h01);
      peek(4'd4, rv); check("add_r4", rv, 16'h0000);
      issue(4'd6, 4'd5, 4'd0, 1, 16'h7FFF, 1);
      check("mov_keeps_psr", psr, 8'h01);
      issue(4'd3, 4'd5, 4'd0, 1, 16'h0001, 1);
      check("add_ovf_res", result, 16'h8000);
      check("add_ovf_psr", psr, 8'h20);
      issue(4'd4, 4'd4, 4'd0, 1, 16'h0001, 1);
      check("sub_borrow_res", result, 16'hFFFF);
      check("sub_borrow_psr", psr, 8'h01);

      // Compare
      issue(4'd6, 4'd6, 4'd0, 1, 16'h0001, 1);
      issue(4'd5, 4'd6, 4'd0, 1, 16'hFFFF, 1);
      check("cmp_lt_u_res", result, 0);
      check("cmp_lt_u_valid", result_valid, 1);
      check("cmp_lt_u_psr", psr, 8'h05);
      peek(4'd6, rv); check("cmp_no_write", rv, 16'h0001);
      issue(4'd5, 4'd6, 4'd0, 1, 16'h0001, 1);
      check("cmp_eq_psr", psr, 8'h41);
      issue(4'd5, 4'd4, 4'd0, 1, 16'h0001, 1);
      check("cmp_lt_s_psr", psr, 8'h81);

      // Shifts and LUI
      issue(4'd6, 4'd7, 4'd0, 1, 16'h8001, 1);
      issue(4'd7, 4'd7, 4'd0, 1, 16'h0001, 0);
      check("lsh_l1", result, 16'h0002);
      issue(4'd7, 4'd7, 4'd0, 1, 16'h001F, 0);
      check("lsh_r1", result, 16'h4000);
      issue(4'd7, 4'd7, 4'd0, 1, 16'h000F, 0);
      check("lsh_l15", result, 16'h8000);
      issue(4'd7, 4'd7, 4'd0, 1, 16'h0010, 0);
      check("lsh_r16", result, 16'h0000);
      issue(4'd8, 4'd7, 4'd0, 1, 16'h0001, 0);
      check("ash_l1", result, 16'h0002);
      issue(4'd8, 4'd7, 4'd0, 1, 16'h001F, 0);
      check("ash_r1", result, 16'hC000);
      issue(4'd6, 4'd8, 4'd0, 1, 16'h8000, 1);
      issue(4'd8, 4'd8, 4'd0, 1, 16'h0011, 0);
      check("ash_r15", result, 16'hFFFF);
      issue(4'd8, 4'd8, 4'd0, 1, 16'h0010, 0);
      check("ash_r16", result, 16'hFFFF);
      issue(4'd10, 4'd3, 4'd0, 1, 16'h0012, 1);
      check("lui_result", result, 16'h1200);
      peek(4'd3, rv); check("lui_r3", rv, 16'h1200);
      check("shift_psr_kept", psr, 8'h81);

      // Reserved op
      issue(4'd11, 4'd7, 4'd0, 1, 16'h5A5A, 1);
      check("rsv_result", result, 0);
      check("rsv_valid", result_valid, 1);
      check("rsv_psr", psr, 8'h81);
      peek(4'd7, rv); check("rsv_no_write", rv, 16'h8001);

      // Back-to-back dependent instructions
      issue(4'd6, 4'd11, 4'd0, 1, 16'h0005, 1);
      issue(4'd3, 4'd11, 4'd0, 1, 16'h0003, 1);
      check("b2b_result", result, 16'h0008);
      check("b2b_psr", psr, 8'h80);

      // Multiply with issue_valid held high throughout
      issue(4'd6, 4'd9, 4'd0, 1, 16'h0012, 1);
      issue(4'd6, 4'd10, 4'd0, 1, 16'h0034, 1);
      op = 4'd9; rdest = 4'd9; rsrc = 4'd10; use_imm = 1'b0; write_en = 1'b1;
      issue_valid = 1'b1;
      @(posedge clk); #1;
      op = 4'd6; use_imm = 1'b1; imm = 16'hDEAD;
      busy = 0; pulses = 0;
      while (!issue_ready && busy < 40) begin
         busy++;
         if (result_valid) pulses++;
         @(posedge clk); #1;
      end
      issue_valid = 1'b0;
      check("mul_busy_cycles", busy, 16);
      check("mul_busy_pulses", pulses, 0);
      check("mul_valid", result_valid, 1);
      check("mul_result", result, 16'h03A8);
      check("mul_psr", psr, 8'h80);
      peek(4'd9, rv); check("mul_r9", rv, 16'h03A8);
      @(posedge clk); #1;
      check("mul_pulse_end", result_valid, 0);
      peek(4'd9, rv); check("mul_ignored_req", rv, 16'h03A8);

      // Reset in the middle of a multiply
      issue(4'd6, 4'd12, 4'd0, 1, 16'h0007, 1);
      issue(4'd6, 4'd13, 4'd0, 1, 16'h0009, 1);
      issue(4'd9, 4'd12, 4'd13, 0, 16'h0000, 1);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check("abort_ready", issue_ready, 1);
      check("abort_psr", psr, 8'h00);
      check("abort_result", result, 0);
      pulses = 0;
      for (int i = 0; i < 24; i++) begin
         if (result_valid) pulses++;
         @(posedge clk); #1;
      end
      check("abort_no_pulse", pulses, 0);
      peek(4'd12, rv); check("abort_r12", rv, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rf_alu_exec.md
# rf_alu_exec

Parametrised execute unit for the 16-bit CR16-style CPU datapath. It combines a register file, ALU, shifter and an iterative multiplier behind a valid/ready issue handshake. It registers results and PSR flags, and writes back to the register file on the accepting edge. It generalises the fixed-width RF/ALU datapath in width and register count, and adds multi-cycle operations with back-pressure.

## Interface
Parameters:
- WIDTH, 16, datapath and register width (even, ≥ 8)
- REGBITS, 4, register address bits; 2^REGBITS registers
- SHBITS, $clog2(WIDTH)+1, signed shift-amount field width taken from operand B

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- issue_valid  in  1  instruction present
- issue_ready  out  1  unit can accept; combinational = !busy
- op  in  4  operation code (see Operation)
- rdest  in  REGBITS  destination, also source A
- rsrc  in  REGBITS  source B register
- use_imm  in  1  1: B = imm; 0: B = RF[rsrc]
- imm  in  WIDTH  immediate (pre-extended by decoder)
- write_en  in  1  allow register writeback
- result  out  WIDTH  registered result
- result_valid  out  1  one-cycle pulse per completed instruction
- psr  out  8  flags: C bit0, L bit2, F bit5, Z bit6, N bit7, others 0
- dbg_addr  in  REGBITS  debug read address
- dbg_data  out  WIDTH  combinational RF[dbg_addr]

## Operation
- A = RF[rdest] and B = use_imm ? imm : RF[rsrc], sampled at the accept edge (issue_valid && issue_ready).
- Ops:
  - 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB (A−B), 5 CMP, 6 MOV (B)
  - 7 LSH, 8 ASH, 9 MUL (low WIDTH bits of A*B, unsigned), 10 LUI (B << WIDTH/2)
  - 11–15 reserved
- Shifts: amount s = signed B[SHBITS-1:0]. s>0 shifts left, s<0 shifts right by |s|.
  - LSH zero-fills. ASH sign-fills on right shifts and zero-fills on left shifts.
  - |s| ≥ WIDTH gives 0 for LSH and for ASH left shifts; an ASH right shift by |s| ≥ WIDTH gives all copies of the sign bit.
- Writeback: RF[rdest] ← result when write_en=1 and op ∈ {0–4,6–10}.
  - CMP and reserved ops never write.
  - Register 0 is an ordinary register.
- Flags, updated only by the listed ops; all other ops leave psr unchanged:
  - ADD: C = carry out, F = signed overflow.
  - SUB: C = borrow (A<B unsigned), F = signed overflow.
  - CMP: Z = (A==B), N = (A<B signed), L = (A<B unsigned); result = 0.
- Reserved ops: result = 0, result_valid pulses, no write, no flag change.
- MUL state machine, two states:
  - IDLE: issue_ready=1. An accepted MUL latches A, B and rdest, loads counter = WIDTH and moves to BUSY.
  - BUSY: issue_ready=0. One shift-add step per cycle and the counter decrements. When the counter reaches 0, the unit writes back, drives result and result_valid, and returns to IDLE.
  - issue_valid during BUSY is ignored: no side effects.
- Reset: all RF entries 0, psr=0, result=0, result_valid=0, state IDLE, issue_ready=1. Reset during BUSY aborts the multiply with no writeback.

## Timing
- Single-cycle ops: accepted at edge N. RF write, result and psr all update at edge N, so result_valid=1 during cycle N→N+1 only.
- Back-to-back issue every cycle is supported. An instruction accepted at edge N+1 reads the value written at edge N, so there is no hazard and no forwarding is needed.
- MUL: accepted at edge N; issue_ready=0 during cycles N..N+WIDTH−1.
  - Writeback and result update happen at edge N+WIDTH, with result_valid=1 in the following cycle.
  - issue_ready=1 again in that cycle, so the next instruction is accepted at edge N+WIDTH+1 at the earliest.
- result holds its value between pulses.
- dbg_data reflects writes from the edge just passed.

## Test plan
Values for WIDTH=16, REGBITS=4.
1. Reset. MOV imm 0xAAAA→r0, MOV imm 0xFFFF→r1, then AND r0,r1 → result=0xAAAA with a 1-cycle result_valid pulse; dbg r0=0xAAAA; psr=0x00.
2. ADD 0xFFFF+0x0001 → 0x0000, C=1, F=0. ADD 0x7FFF+0x0001 → 0x8000, F=1, C=0. SUB 0x0000−0x0001 → 0xFFFF, C=1.
3. CMP r=0x0001 vs imm 0xFFFF → L=1, N=0, Z=0. r unchanged; C/F retain prior values.
4. LSH 0x8001 by imm 0x0001 → 0x0002. LSH 0x8001 by imm 0x001F (−1) → 0x4000. ASH 0x8000 by imm 0x0011 (−15) → 0xFFFF. LUI imm 0x0012 → 0x1200.
5. MUL 0x0012*0x0034 with issue_valid held high → issue_ready low for exactly 16 cycles; extra requests are ignored; result=0x03A8 with valid in cycle 17; RF updated.
6. Assert reset in cycle 5 of a MUL → destination stays 0, issue_ready=1, psr=0, result_valid never pulses.
